// File: rtl/mem_copy_engine_if.sv
// rtl/mem_copy_engine_if.sv - control handshake and memory-bus bundle for mem_copy_engine
interface mem_copy_engine_if #(
    parameter int DATA_W = 32
);
    logic              i_start;
    logic              i_mode;
    logic [DATA_W-1:0] i_src;
    logic [DATA_W-1:0] i_dst;
    logic [DATA_W-1:0] i_len;
    logic [DATA_W-1:0] i_fill;
    logic              o_busy;
    logic              o_done;
    logic              o_err;
    logic [DATA_W-1:0] o_count;
    logic [DATA_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_in;
    logic              o_mem_wr;
    logic [DATA_W-1:0] i_mem_out;

    // Engine side: takes requests and read data, drives status and the memory bus.
    modport slave (
        input  i_start, i_mode, i_src, i_dst, i_len, i_fill, i_mem_out,
        output o_busy, o_done, o_err, o_count, o_mem_addr, o_mem_in, o_mem_wr
    );

    // Controller/memory side: issues requests and returns read data.
    modport master (
        output i_start, i_mode, i_src, i_dst, i_len, i_fill, i_mem_out,
        input  o_busy, o_done, o_err, o_count, o_mem_addr, o_mem_in, o_mem_wr
    );
endinterface

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - block COPY/FILL engine driving a single-port memory
module mem_copy_engine #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                i_clk,
    input  logic                i_rst,
    mem_copy_engine_if.slave    bus
);
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FIN} state_t;

    localparam logic [DATA_W:0]   DEPTH_X = (DATA_W+1)'(DEPTH);
    localparam logic [DATA_W-1:0] ONE     = DATA_W'(1);

    state_t            r_state;
    logic              r_mode;
    logic [DATA_W-1:0] r_src;
    logic [DATA_W-1:0] r_dst;
    logic [DATA_W-1:0] r_len;
    logic [DATA_W-1:0] r_idx;
    // Holds the word read in RD for COPY, or the constant for FILL; it is the MEM_IN register.
    logic [DATA_W-1:0] r_buf;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [DATA_W-1:0] r_count;
    logic [DATA_W-1:0] r_mem_addr;
    logic              r_mem_wr;

    state_t            w_state;
    logic              w_mode;
    logic [DATA_W-1:0] w_src;
    logic [DATA_W-1:0] w_dst;
    logic [DATA_W-1:0] w_len;
    logic [DATA_W-1:0] w_idx;
    logic [DATA_W-1:0] w_buf;
    logic              w_busy;
    logic              w_done;
    logic              w_err;
    logic [DATA_W-1:0] w_count;
    logic [DATA_W-1:0] w_mem_addr;
    logic              w_mem_wr;

    logic [DATA_W:0]   w_dst_end;
    logic [DATA_W:0]   w_src_end;
    logic              w_reject;
    logic [DATA_W-1:0] w_idx_inc;
    logic              w_last;

    // One extra bit keeps base+length from wrapping past the end of memory.
    assign w_dst_end = {1'b0, bus.i_dst} + {1'b0, bus.i_len};
    assign w_src_end = {1'b0, bus.i_src} + {1'b0, bus.i_len};
    assign w_reject  = (w_dst_end > DEPTH_X) || (!bus.i_mode && (w_src_end > DEPTH_X));
    assign w_idx_inc = r_idx + ONE;
    assign w_last    = (w_idx_inc == r_len);

    // Next state and next value of every registered output; each register is loaded
    // with the value its output must show in the state being entered.
    always_comb begin
        w_state    = r_state;
        w_mode     = r_mode;
        w_src      = r_src;
        w_dst      = r_dst;
        w_len      = r_len;
        w_idx      = r_idx;
        w_buf      = r_buf;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_err      = 1'b0;
        w_count    = r_count;
        w_mem_addr = r_mem_addr;
        w_mem_wr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    w_mode  = bus.i_mode;
                    w_src   = bus.i_src;
                    w_dst   = bus.i_dst;
                    w_len   = bus.i_len;
                    w_idx   = '0;
                    w_count = '0;
                    if (w_reject || (bus.i_len == '0)) begin
                        w_state = S_FIN;
                        w_done  = 1'b1;
                        w_err   = w_reject;
                        w_busy  = 1'b0;
                    end else if (!bus.i_mode) begin
                        w_state    = S_RD;
                        w_busy     = 1'b1;
                        w_mem_addr = bus.i_src;
                    end else begin
                        w_state    = S_WR;
                        w_busy     = 1'b1;
                        w_mem_addr = bus.i_dst;
                        w_buf      = bus.i_fill;
                        w_mem_wr   = 1'b1;
                    end
                end
            end
            S_RD: begin
                w_state    = S_WR;
                w_buf      = bus.i_mem_out;
                w_mem_addr = r_dst + r_idx;
                w_mem_wr   = 1'b1;
            end
            S_WR: begin
                w_count = r_count + ONE;
                w_idx   = w_idx_inc;
                if (w_last) begin
                    w_state = S_FIN;
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                end else if (!r_mode) begin
                    w_state    = S_RD;
                    w_mem_addr = r_src + w_idx_inc;
                end else begin
                    w_mem_addr = r_dst + w_idx_inc;
                    w_mem_wr   = 1'b1;
                end
            end
            S_FIN: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
            end
            default: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any transfer without a DONE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_mode     <= 1'b0;
            r_src      <= '0;
            r_dst      <= '0;
            r_len      <= '0;
            r_idx      <= '0;
            r_buf      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_count    <= '0;
            r_mem_addr <= '0;
            r_mem_wr   <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_mode     <= w_mode;
            r_src      <= w_src;
            r_dst      <= w_dst;
            r_len      <= w_len;
            r_idx      <= w_idx;
            r_buf      <= w_buf;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_err      <= w_err;
            r_count    <= w_count;
            r_mem_addr <= w_mem_addr;
            r_mem_wr   <= w_mem_wr;
        end
    end

    assign bus.o_busy     = r_busy;
    assign bus.o_done     = r_done;
    assign bus.o_err      = r_err;
    assign bus.o_count    = r_count;
    assign bus.o_mem_addr = r_mem_addr;
    assign bus.o_mem_in   = r_buf;
    assign bus.o_mem_wr   = r_mem_wr;
endmodule
